// File: rtl/gate_pipe_if.sv
// gate_pipe_if: handshake and data bundle for gate_pipe.
//   in_valid/in_ready : upstream operand-set handshake
//   a, b, c, op1, op2 : operands and per-transaction gate selects
//   out_valid/out_ready: downstream result handshake
//   y                 : result
//   ones              : popcount of y (only with GATE_PIPE_POPCOUNT_EN)
// master = upstream/downstream environment, slave = gate_pipe.
interface gate_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [1:0]       op1;
  logic [1:0]       op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;

`ifdef GATE_PIPE_POPCOUNT_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);
  logic [CW-1:0]    ones;

  modport master (
    output in_valid, a, b, c, op1, op2, out_ready,
    input  in_ready, out_valid, y, ones
  );

  modport slave (
    input  in_valid, a, b, c, op1, op2, out_ready,
    output in_ready, out_valid, y, ones
  );
`else
  modport master (
    output in_valid, a, b, c, op1, op2, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, c, op1, op2, out_ready,
    output in_ready, out_valid, y
  );
`endif
endinterface

// File: rtl/gate_pipe.sv
// gate_pipe: two-stage bitwise gate pipeline with valid/ready flow control.
//   Stage 1 registers s1 = op1(a,b) along with c and op2.
//   Stage 2 registers y = op2(s1,c) (and its popcount when enabled).
// Gate codes: 00 AND, 01 OR, 10 XOR, 11 NAND.
// Ports:
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset, clears both stages
//   bus     : gate_pipe_if.slave (handshakes, operands, result)
// Optional feature: define GATE_PIPE_POPCOUNT_EN to add the registered
// 'ones' output (population count of y).
module gate_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  gate_pipe_if.slave  bus
);

  function automatic logic [WIDTH-1:0] gate(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = x & z;
      2'b01:   r = x | z;
      2'b10:   r = x ^ z;
      default: r = ~(x & z);
    endcase
    return r;
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] s1_c;
  logic [1:0]       s1_op2;
  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] s2_next;

  logic s2_free_c;
  logic s1_adv_c;
  logic in_ready_c;
  logic in_xfer_c;

  // Flow control: stage 1 is free when empty or moving into stage 2 this edge.
  always_comb begin
    s2_free_c  = !out_valid_q || bus.out_ready;
    s1_adv_c   = s1_valid && s2_free_c;
    in_ready_c = !s1_valid || s1_adv_c;
    in_xfer_c  = bus.in_valid && in_ready_c;
    s2_next    = gate(s1_op2, s1_data, s1_c);
  end

  // Stage 1: capture first gate result plus the operands stage 2 needs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_c     <= '0;
      s1_op2   <= 2'b00;
    end else if (in_xfer_c) begin
      s1_valid <= 1'b1;
      s1_data  <= gate(bus.op1, bus.a, bus.b);
      s1_c     <= bus.c;
      s1_op2   <= bus.op2;
    end else if (s1_adv_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result register; holds while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else if (s1_adv_c) begin
      out_valid_q <= 1'b1;
      y_q         <= s2_next;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef GATE_PIPE_POPCOUNT_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  logic [CW-1:0] ones_q;

  // Popcount is computed from the same next value as y so it shares y's timing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ones_q <= '0;
    end else if (s1_adv_c) begin
      ones_q <= popcount(s2_next);
    end
  end

  assign bus.ones = ones_q;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;

endmodule

// File: tb/tb_gate_pipe.sv
// tb_gate_pipe: self-checking bench for gate_pipe (WIDTH=8).
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// later, so every handshake seen here is the one taken on the next rising edge.
module tb_gate_pipe;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  gate_pipe_if #(.WIDTH(WIDTH)) bus ();

  gate_pipe #(.WIDTH(WIDTH)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];

  function automatic logic [7:0] ref_gate(input logic [1:0] op, input logic [7:0] x, input logic [7:0] z);
    case (op)
      2'd0:    return x & z;
      2'd1:    return x | z;
      2'd2:    return x ^ z;
      default: return ~(x & z);
    endcase
  endfunction

  function automatic logic [7:0] ref_result(input logic [7:0] ia, ib, ic, input logic [1:0] o1, o2);
    return ref_gate(o2, ref_gate(o1, ia, ib), ic);
  endfunction

  function automatic logic [3:0] read_ones();
`ifdef GATE_PIPE_POPCOUNT_EN
    return bus.ones;
`else
    return 4'd0;
`endif
  endfunction

  // One cycle: drive at negedge, sample the handshakes about to be taken.
  task automatic drive(input logic iv, input logic [7:0] ia, ib, ic,
                       input logic [1:0] o1, o2, input logic ordy,
                       output logic acc, output logic took,
                       output logic [7:0] yv, output logic [3:0] ov, output logic ir);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.c         = ic;
    bus.op1       = o1;
    bus.op2       = o2;
    bus.out_ready = ordy;
    #1;
    ir   = bus.in_ready;
    acc  = iv && bus.in_ready;
    took = bus.out_valid && ordy;
    yv   = bus.y;
    ov   = read_ones();
  endtask

  task automatic apply_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 8'h00; bus.b = 8'h00; bus.c = 8'h00; bus.op1 = 2'd0; bus.op2 = 2'd0;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.y !== 8'h00) begin errors++; $display("FAIL reset_y got %h want 00", bus.y); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
`ifdef GATE_PIPE_POPCOUNT_EN
    checks++;
    if (bus.ones !== 4'd0) begin errors++; $display("FAIL reset_ones got %0d want 0", bus.ones); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic acc, took, ir;
    logic [7:0] yv;
    logic [3:0] ov;
    apply_reset();
    drive(1'b1, 8'hF0, 8'h3C, 8'h01, 2'd0, 2'd1, 1'b1, acc, took, yv, ov, ir);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", acc); end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd3, 2'd3, 1'b1, acc, took, yv, ov, ir);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", bus.out_valid); end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd3, 2'd3, 1'b1, acc, took, yv, ov, ir);
    checks++;
    if (took !== 1'b1 || yv !== 8'h31) begin errors++; $display("FAIL single_result got valid=%b y=%h want valid=1 y=31", took, yv); end
`ifdef GATE_PIPE_POPCOUNT_EN
    checks++;
    if (ov !== 4'd3) begin errors++; $display("FAIL single_ones got %0d want 3", ov); end
`endif
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 1'b1, acc, took, yv, ov, ir);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_no_dup got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic acc, took, ir;
    logic [7:0] yv;
    logic [3:0] ov;
    logic [7:0] want [4];
    int n = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    want[0] = 8'h0A; want[1] = 8'hAF; want[2] = 8'hA5; want[3] = 8'hF5;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        drive(1'b1, 8'hAA, 8'h0F, 8'h00, 2'(i), 2'd2, 1'b1, acc, took, yv, ov, ir);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d got %b want 1", i, acc); end
      end else begin
        drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 1'b1, acc, took, yv, ov, ir);
      end
      if (took) begin
        if (first_cyc < 0) first_cyc = i;
        last_cyc = i;
        checks++;
        if (n >= 4 || yv !== want[n % 4]) begin
          errors++; $display("FAIL b2b_y%0d got %h want %h", n, yv, want[n % 4]);
        end
        n++;
      end
    end
    checks++;
    if (n != 4 || first_cyc != 2 || last_cyc - first_cyc != 3) begin
      errors++; $display("FAIL b2b_timing got count=%0d first=%0d last=%0d want count=4 first=2 last=5", n, first_cyc, last_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic acc, took, ir;
    logic [7:0] yv, y_hold, ia;
    logic [3:0] ov;
    int accepts = 0;
    int got = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      ia = 8'(8'h11 * (i + 1));
      drive(1'b1, ia, 8'hFF, 8'h5A, 2'd0, 2'd2, 1'b0, acc, took, yv, ov, ir);
      if (acc) begin
        accepts++;
        exp_q.push_back(ref_result(ia, 8'hFF, 8'h5A, 2'd0, 2'd2));
      end
      if (i == 2) y_hold = yv;
      if (i >= 2) begin
        checks++;
        if (ir !== 1'b0 || bus.out_valid !== 1'b1 || yv !== y_hold) begin
          errors++; $display("FAIL stall_hold%0d got in_ready=%b valid=%b y=%h want 0 1 %h", i, ir, bus.out_valid, yv, y_hold);
        end
      end
    end
    checks++;
    if (accepts != 2) begin errors++; $display("FAIL stall_accepts got %0d want 2", accepts); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 1'b1, acc, took, yv, ov, ir);
      if (took) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra got y=%h want none", yv);
        end else begin
          if (yv !== exp_q[0]) begin errors++; $display("FAIL stall_order got %h want %h", yv, exp_q[0]); end
          void'(exp_q.pop_front());
          got++;
        end
      end
    end
    checks++;
    if (got != 2) begin errors++; $display("FAIL stall_delivered got %0d want 2", got); end
  endtask

  task automatic test_async_reset();
    logic acc, took, ir;
    logic [7:0] yv;
    logic [3:0] ov;
    apply_reset();
    for (int i = 0; i < 3; i++)
      drive(1'b1, 8'hC3, 8'h3C, 8'h0F, 2'd1, 2'd0, 1'b0, acc, took, yv, ov, ir);
    checks++;
    if (bus.out_valid !== 1'b1 || ir !== 1'b0) begin
      errors++; $display("FAIL areset_full got valid=%b in_ready=%b want 1 0", bus.out_valid, ir);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.y !== 8'h00 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_clear got valid=%b y=%h in_ready=%b want 0 00 1", bus.out_valid, bus.y, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 1'b1, acc, took, yv, ov, ir);
      checks++;
      if (took !== 1'b0) begin errors++; $display("FAIL areset_stale%0d got y=%h want no output", i, yv); end
    end
  endtask

  task automatic test_nand();
    logic acc, took, ir;
    logic [7:0] yv;
    logic [3:0] ov;
    apply_reset();
    drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 2'd3, 2'd3, 1'b1, acc, took, yv, ov, ir);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 1'b1, acc, took, yv, ov, ir);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 1'b1, acc, took, yv, ov, ir);
    checks++;
    if (took !== 1'b1 || yv !== 8'hFF) begin errors++; $display("FAIL nand_y got valid=%b y=%h want 1 FF", took, yv); end
`ifdef GATE_PIPE_POPCOUNT_EN
    checks++;
    if (ov !== 4'd8) begin errors++; $display("FAIL nand_ones got %0d want 8", ov); end
`endif
  endtask

  task automatic test_random();
    logic acc, took, ir, iv, ordy;
    logic [7:0] yv, ia, ib, ic;
    logic [1:0] o1, o2;
    logic [3:0] ov;
    int pending;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      iv   = 1'($urandom % 2);
      ordy = ($urandom % 4) != 0;
      ia = 8'($urandom); ib = 8'($urandom); ic = 8'($urandom);
      o1 = 2'($urandom); o2 = 2'($urandom);
      pending = exp_q.size();
      drive(iv, ia, ib, ic, o1, o2, ordy, acc, took, yv, ov, ir);
      checks++;
      if (ir !== ((pending < 2) || ordy)) begin
        errors++; $display("FAIL rand_in_ready%0d got %b want %b (pending=%0d)", i, ir, (pending < 2) || ordy, pending);
      end
      if (took) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra%0d got y=%h want none", i, yv);
        end else begin
          if (yv !== exp_q[0]) begin errors++; $display("FAIL rand_y%0d got %h want %h", i, yv, exp_q[0]); end
`ifdef GATE_PIPE_POPCOUNT_EN
          checks++;
          if (ov !== 4'($countones(exp_q[0]))) begin errors++; $display("FAIL rand_ones%0d got %0d want %0d", i, ov, $countones(exp_q[0])); end
`endif
          void'(exp_q.pop_front());
        end
      end
      if (acc) exp_q.push_back(ref_result(ia, ib, ic, o1, o2));
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 1'b1, acc, took, yv, ov, ir);
      if (took) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL drain_extra got y=%h want none", yv);
        end else begin
          if (yv !== exp_q[0]) begin errors++; $display("FAIL drain_y got %h want %h", yv, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_lost got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_nand();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_pipe.md
GATE_PIPE -- requirements
Module: gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, meaning bit width of every data operand and result; legal range 1..64.
REQ-002 Port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port in_valid  input  1  upstream presents an operand set this cycle.
REQ-005 Port in_ready  output  1  block accepts operand set this cycle.
REQ-006 Port a, b, c  input  WIDTH each  operands; stage-1 combines a with b, stage-2 combines that with c.
REQ-007 Port op1, op2  input  2 each  per-transaction gate select for stage 1 and stage 2.
REQ-008 Port out_valid  output  1  y holds a result.
REQ-009 Port out_ready  input  1  downstream consumes y this cycle.
REQ-010 Port y  output  WIDTH  result.
REQ-011 Port ones  output  $clog2(WIDTH+1)  population count of y; present only per REQ-027.

Function
REQ-012 Gate encoding SHALL be 00 AND, 01 OR, 10 XOR, 11 NAND, bitwise across WIDTH.
REQ-013 Input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; output transfer when out_valid and out_ready are both 1.
REQ-014 Stage 1 SHALL register s1 = op1(a,b), plus c and op2, with s1_valid, on input transfer.
REQ-015 Stage 2 SHALL register y = op2(s1,c) and set out_valid when s1_valid and stage 2 is free or draining.
REQ-016 Stage 2 free/draining SHALL mean out_valid=0 or out_ready=1; stage 1 free SHALL mean s1_valid=0 or stage 1 advances this cycle.
REQ-017 in_ready SHALL equal stage-1 free, combinationally from registered state and out_ready only (no dependence on in_valid).
REQ-018 Latency SHALL be 2 cycles from input transfer to out_valid with no backpressure; throughput one transfer per cycle sustained.
REQ-019 While out_valid=1 and out_ready=0, y and out_valid SHALL hold stable; stage 1 holds if full; in_ready=0 once both stages full.
REQ-020 Simultaneous output transfer and stage-1 advance SHALL replace y with new result in the same edge, no bubble, no loss.
REQ-021 Transactions SHALL emerge in acceptance order; none dropped or duplicated.
REQ-022 op1/op2 SHALL be sampled only at the transaction's own transfer; later changes do not affect it.

Reset
REQ-023 reset_n low SHALL asynchronously clear s1_valid, out_valid, all data registers (y=0, ones=0).
REQ-024 During reset in_ready SHALL read 1 once reset_n low is applied (both stages empty).
REQ-025 Reset mid-operation SHALL discard all in-flight transactions; first edge after release behaves as empty pipe.
REQ-026 Reset release SHALL be synchronised externally; block imposes no extra release delay.

Configuration
REQ-027 Macro GATE_PIPE_POPCOUNT_EN defined: ones port exists and is registered in stage 2 alongside y, equal to popcount of y, same valid, same hold rules.
REQ-028 Macro GATE_PIPE_POPCOUNT_EN undefined: ones port and counting logic absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-029 Reset then idle: reset_n=0 -> out_valid=0, y=8'h00, in_ready=1.
REQ-030 Single transfer a=8'hF0,b=8'h3C,op1=AND,c=8'h01,op2=OR, out_ready=1 -> out_valid exactly 2 edges later, y=8'h31, ones=3 when enabled.
REQ-031 Back-to-back 4 transfers, all four op1 codes, a=8'hAA,b=8'h0F,c=8'h00,op2=XOR -> y sequence 8'h0A, 8'hAF, 8'hA5, 8'hF5 on consecutive cycles.
REQ-032 out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts, y stable; release -> both results delivered in order, no loss.
REQ-033 reset_n pulsed low with both stages full -> out_valid=0 immediately (async), no stale result after release.
REQ-034 Macro build pair: NAND/NAND with a=b=c=8'hFF -> y=8'hFF, ones=8 with macro; same y, no ones port without.
